// File: rtl/page_walker.sv
// page_walker: multi-level page-table walker servicing one TLB miss at a time.
// It issues one PTE read per level, then returns a translation or a fault to the TLB.
module page_walker #(
    parameter int SADDR  = 64,  // address width
    parameter int SPAGE  = 12,  // page-offset width
    parameter int SPCID  = 12,  // process-context identifier width
    parameter int LEVELS = 3,   // page-table levels
    parameter int SIDX   = 9    // VA index bits per level
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [SADDR-1:0] root_base,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SADDR-1:0] req_va,
    input  logic [SPCID-1:0] req_pcid,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [SADDR-1:0] mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [SADDR-1:0] mem_resp_data,
    output logic             fill_valid,
    input  logic             fill_ready,
    output logic [SADDR-1:0] fill_va,
    output logic [SPCID-1:0] fill_pcid,
    output logic [SADDR-1:0] fill_pa,
    output logic             fill_fault,
    output logic             busy
);
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t           state, state_nx;
    logic [SADDR-1:0] va_q, va_nx;
    logic [SPCID-1:0] pcid_q, pcid_nx;
    logic [SADDR-1:0] base_q, base_nx;
    logic [LW-1:0]    lvl_q, lvl_nx;
    logic [SADDR-1:0] pa_q, pa_nx;
    logic             fault_q, fault_nx;

    logic [SADDR-1:0] va_shift;
    logic [SIDX-1:0]  idx;
    logic             last;
    logic             unused_pte_bits;

    // Index for the current level: the top level uses the most significant VA slice.
    assign va_shift = va_q >> (SPAGE + SIDX * (LEVELS - 1 - int'(lvl_q)));
    assign idx      = va_shift[SIDX-1:0];
    assign last     = (lvl_q == LW'(LEVELS - 1));

    // PTE flag bits between the leaf bit and the PPN carry no meaning here.
    assign unused_pte_bits = ^mem_resp_data[SPAGE-1:2];

    assign req_ready     = (state == IDLE) && !rst && !flush;
    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = base_q + {{(SADDR-SIDX-3){1'b0}}, idx, 3'b000};
    assign fill_valid    = (state == DONE);
    assign fill_va       = va_q;
    assign fill_pcid     = pcid_q;
    assign fill_pa       = pa_q;
    assign fill_fault    = fault_q;
    assign busy          = (state != IDLE);

    // Walk state register and captured request/translation context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            va_q    <= '0;
            pcid_q  <= '0;
            base_q  <= '0;
            lvl_q   <= '0;
            pa_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nx;
            va_q    <= va_nx;
            pcid_q  <= pcid_nx;
            base_q  <= base_nx;
            lvl_q   <= lvl_nx;
            pa_q    <= pa_nx;
            fault_q <= fault_nx;
        end
    end

    // Next-state and datapath updates; flush is checked before any other event.
    always_comb begin
        state_nx = state;
        va_nx    = va_q;
        pcid_nx  = pcid_q;
        base_nx  = base_q;
        lvl_nx   = lvl_q;
        pa_nx    = pa_q;
        fault_nx = fault_q;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    va_nx    = req_va;
                    pcid_nx  = req_pcid;
                    base_nx  = root_base;
                    lvl_nx   = '0;
                    pa_nx    = '0;
                    fault_nx = 1'b0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                // A read accepted in the same cycle as flush still returns data later.
                if (flush)              state_nx = mem_req_ready ? DRAIN : IDLE;
                else if (mem_req_ready) state_nx = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_nx = mem_resp_valid ? IDLE : DRAIN;
                end else if (mem_resp_valid) begin
                    if (!mem_resp_data[0] || (mem_resp_data[1] != last)) begin
                        // Invalid PTE, superpage leaf, or non-leaf at the last level.
                        pa_nx    = '0;
                        fault_nx = 1'b1;
                        state_nx = DONE;
                    end else if (last) begin
                        pa_nx    = {mem_resp_data[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
                        fault_nx = 1'b0;
                        state_nx = DONE;
                    end else begin
                        base_nx  = {mem_resp_data[SADDR-1:SPAGE], {SPAGE{1'b0}}};
                        lvl_nx   = lvl_q + LW'(1);
                        state_nx = REQ;
                    end
                end
            end
            DONE: begin
                if (flush || fill_ready) state_nx = IDLE;
            end
            DRAIN: begin
                if (!flush && mem_resp_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker: directed vectors against a small PTE memory model with
// programmable read backpressure and response delay.
module tb_page_walker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [63:0] root_base = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_va = '0;
    logic [11:0] req_pcid = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        fill_valid;
    logic        fill_ready = 1'b1;
    logic [63:0] fill_va;
    logic [11:0] fill_pcid;
    logic [63:0] fill_pa;
    logic        fill_fault;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;

    // memory model state
    logic [63:0] mem [logic [63:0]];
    logic [63:0] log_q [$];
    int          resp_delay = 1;
    int          stall = 0;
    int          unstable = 0;
    int          fills = 0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] pdata = '0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_addr = '0;

    page_walker dut (
        .clk(clk), .rst(rst), .flush(flush), .root_base(root_base),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_va(fill_va),
        .fill_pcid(fill_pcid), .fill_pa(fill_pa), .fill_fault(fill_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: drives ready/response for the next rising edge.
    always @(negedge clk) begin
        if (prev_stall && (!mem_req_valid || mem_req_addr != prev_addr)) unstable++;
        mem_resp_valid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = pdata;
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
        mem_req_ready = (stall == 0);
        if (mem_req_valid && stall > 0) stall--;
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        if (mem_req_valid && mem_req_ready) begin
            log_q.push_back(mem_req_addr);
            pend  = 1'b1;
            cnt   = resp_delay;
            pdata = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 64'h0;
        end
    end

    // Count accepted fills.
    always @(posedge clk) if (fill_valid && fill_ready) fills++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic [63:0] va, input logic [11:0] pcid);
        int n = 0;
        req_va = va; req_pcid = pcid; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_fill(output int cyc);
        cyc = 1;
        while (!fill_valid && cyc < 200) begin @(negedge clk); cyc++; end
        chk("fill_seen", fill_valid, 1);
    endtask

    task automatic check_log(input string tag, input int n,
                             input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2);
        logic [63:0] exp [3];
        exp[0] = a0; exp[1] = a1; exp[2] = a2;
        chk({tag, "_nreads"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++) chk({tag, "_addr"}, log_q[i], exp[i]);
    endtask

    task automatic normal_walk(input string tag);
        int lat;
        int f0;
        resp_delay = 1; log_q.delete(); f0 = fills; fill_ready = 1'b1;
        start_req(64'h403123, 12'd5);
        wait_fill(lat);
        chk({tag, "_lat"}, lat, 7);
        chk({tag, "_pa"}, fill_pa, 64'h7000_0123);
        chk({tag, "_fault"}, fill_fault, 0);
        chk({tag, "_pcid"}, fill_pcid, 5);
        chk({tag, "_va"}, fill_va, 64'h403123);
        check_log(tag, 3, 64'h1000, 64'h2010, 64'h3018);
        @(negedge clk);
        chk({tag, "_fill_drop"}, fill_valid, 0);
        chk({tag, "_nfills"}, fills - f0, 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic fault_walk(input string tag, input int nreads);
        int lat;
        int f0;
        resp_delay = 1; log_q.delete(); f0 = fills; fill_ready = 1'b1;
        start_req(64'h403123, 12'd5);
        wait_fill(lat);
        chk({tag, "_fault"}, fill_fault, 1);
        chk({tag, "_pa"}, fill_pa, 0);
        check_log(tag, nreads, 64'h1000, 64'h2010, 64'h3018);
        @(negedge clk);
        chk({tag, "_nfills"}, fills - f0, 1);
    endtask

    initial begin
        int lat;
        int n;
        int f0;
        logic [63:0] sv_pa;
        logic [63:0] sv_va;

        mem[64'h1000] = 64'h2001;
        mem[64'h2010] = 64'h3001;
        mem[64'h3018] = 64'h7000_0003;
        root_base = 64'h1000;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_fill_pa", fill_pa, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", req_ready, 1);
        @(negedge clk);

        // normal three-level walk
        normal_walk("t1");

        // invalid level-1 PTE
        mem[64'h2010] = 64'h3000;
        fault_walk("t2", 2);
        mem[64'h2010] = 64'h3001;

        // leaf at level 0
        mem[64'h1000] = 64'h5003;
        fault_walk("t3", 1);
        mem[64'h1000] = 64'h2001;

        // read and fill backpressure
        log_q.delete(); f0 = fills; stall = 4; fill_ready = 1'b0; unstable = 0; resp_delay = 1;
        start_req(64'h403123, 12'd5);
        wait_fill(lat);
        chk("t4_lat", lat, 11);
        sv_pa = fill_pa; sv_va = fill_va;
        chk("t4_pa", sv_pa, 64'h7000_0123);
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_v", fill_valid, 1);
            chk("t4_hold_pa", fill_pa, sv_pa);
            chk("t4_hold_va", fill_va, sv_va);
        end
        fill_ready = 1'b1;
        @(negedge clk);
        chk("t4_fill_drop", fill_valid, 0);
        chk("t4_nfills", fills - f0, 1);
        chk("t4_addr_stable", unstable, 0);
        check_log("t4", 3, 64'h1000, 64'h2010, 64'h3018);

        // flush while waiting on the level-1 read
        log_q.delete(); f0 = fills; resp_delay = 4;
        start_req(64'h403123, 12'd5);
        n = 0;
        while (!(log_q.size() == 2 && !mem_req_valid && busy) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t5_in_wait", n < 100, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("t5_drain_busy", busy, 1);
        chk("t5_drain_ready", req_ready, 0);
        @(negedge clk);
        chk("t5_drain_ready2", req_ready, 0);
        @(negedge clk);
        chk("t5_drain_ready3", req_ready, 0);
        @(negedge clk);
        chk("t5_ready_after_resp", req_ready, 1);
        chk("t5_nreads", log_q.size(), 2);
        chk("t5_nfills", fills - f0, 0);
        normal_walk("t5b");

        // reset during WAIT with a late response
        log_q.delete(); f0 = fills; resp_delay = 3;
        start_req(64'h403123, 12'd9);
        n = 0;
        while (!(log_q.size() == 1 && !mem_req_valid && busy) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("t6_in_wait", n < 100, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_req_ready", req_ready, 0);
        chk("t6_mem_valid", mem_req_valid, 0);
        chk("t6_mem_addr", mem_req_addr, 0);
        chk("t6_fill_valid", fill_valid, 0);
        chk("t6_fill_va", fill_va, 0);
        chk("t6_fill_pcid", fill_pcid, 0);
        chk("t6_fill_pa", fill_pa, 0);
        chk("t6_fill_fault", fill_fault, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after_rst", req_ready, 1);
        repeat (2) @(negedge clk);
        chk("t6_late_busy", busy, 0);
        chk("t6_late_mem_valid", mem_req_valid, 0);
        chk("t6_late_nreads", log_q.size(), 1);
        chk("t6_late_nfills", fills - f0, 0);
        normal_walk("t6b");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
